seg7_capture: RTL and testbench

- Monitors a multiplexed, active-low 7-segment display bus (segment lines plus per-digit anode enables).
- Recovers the hex value shown on each digit. It is the inverse of the hex-to-segment decoder that drives the displays.
- Used in self-check and loopback paths: a board's display output is read back and compared with the intended values.
- Each pattern is committed only after it is stable for a set number of cycles. Unknown patterns are flagged.

---
 rtl/seg7_defs.sv | 33 +++
 rtl/seg7_capture_if.sv | 27 ++
 rtl/seg7_pattern_decode.sv | 39 +++
 rtl/seg7_capture.sv | 121 ++++++++++++
 tb/tb_seg7_capture.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/seg7_defs.sv
// Shared 7-segment glyph constants (active-low, bit6=a .. bit0=g).
// The hex-to-segment decoder that drives the displays uses the same table.
package seg7_defs;

  localparam int SEG_W = 7;
  localparam int NIB_W = 4;

  localparam logic [SEG_W-1:0] SEG_0     = 7'b0000001;
  localparam logic [SEG_W-1:0] SEG_1     = 7'b1001111;
  localparam logic [SEG_W-1:0] SEG_2     = 7'b0010010;
  localparam logic [SEG_W-1:0] SEG_3     = 7'b0000110;
  localparam logic [SEG_W-1:0] SEG_4     = 7'b1001100;
  localparam logic [SEG_W-1:0] SEG_5     = 7'b0100100;
  localparam logic [SEG_W-1:0] SEG_6     = 7'b0100000;
  localparam logic [SEG_W-1:0] SEG_7     = 7'b0001111;
  localparam logic [SEG_W-1:0] SEG_8     = 7'b0000000;
  localparam logic [SEG_W-1:0] SEG_9     = 7'b0000100;
  localparam logic [SEG_W-1:0] SEG_A     = 7'b0001000;
  localparam logic [SEG_W-1:0] SEG_B     = 7'b1100000;
  localparam logic [SEG_W-1:0] SEG_C     = 7'b0110001;
  localparam logic [SEG_W-1:0] SEG_D     = 7'b1000010;
  localparam logic [SEG_W-1:0] SEG_E     = 7'b0110000;
  localparam logic [SEG_W-1:0] SEG_F     = 7'b0111000;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

  // Classification of a stable pattern at commit time.
  typedef enum logic [1:0] {
    CK_GLYPH,
    CK_BLANK,
    CK_ILLEGAL
  } commit_kind_t;

endpackage

// File: rtl/seg7_capture_if.sv
// Display bus (segments + anodes) and recovered-value outputs of the capture block.
// master = board/driver side, slave = the capture block.
interface seg7_capture_if
  import seg7_defs::*;
#(
  parameter int DIGITS = 4
);

  logic [SEG_W-1:0]        seg_n;
  logic [DIGITS-1:0]       an_n;
  logic [NIB_W*DIGITS-1:0] digits_o;
  logic [DIGITS-1:0]       digit_valid;
  logic [DIGITS-1:0]       digit_err;
  logic                    update;
  logic                    err_pulse;

  modport master (
    output seg_n, an_n,
    input  digits_o, digit_valid, digit_err, update, err_pulse
  );

  modport slave (
    input  seg_n, an_n,
    output digits_o, digit_valid, digit_err, update, err_pulse
  );

endinterface

// File: rtl/seg7_pattern_decode.sv
// Combinational inverse of the hex-to-segment decoder: segment pattern -> nibble.
// hit=1 for one of the 16 glyphs, blank=1 for all segments off.
module seg7_pattern_decode
  import seg7_defs::*;
(
  input  logic [SEG_W-1:0] seg_n,
  output logic [NIB_W-1:0] nibble,
  output logic             hit,
  output logic             blank
);

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves one unassigned (no latch).
    nibble = '0;
    hit    = 1'b0;
    blank  = 1'b0;
    case (seg_n)
      SEG_0:     {hit, nibble} = {1'b1, 4'h0};
      SEG_1:     {hit, nibble} = {1'b1, 4'h1};
      SEG_2:     {hit, nibble} = {1'b1, 4'h2};
      SEG_3:     {hit, nibble} = {1'b1, 4'h3};
      SEG_4:     {hit, nibble} = {1'b1, 4'h4};
      SEG_5:     {hit, nibble} = {1'b1, 4'h5};
      SEG_6:     {hit, nibble} = {1'b1, 4'h6};
      SEG_7:     {hit, nibble} = {1'b1, 4'h7};
      SEG_8:     {hit, nibble} = {1'b1, 4'h8};
      SEG_9:     {hit, nibble} = {1'b1, 4'h9};
      SEG_A:     {hit, nibble} = {1'b1, 4'hA};
      SEG_B:     {hit, nibble} = {1'b1, 4'hB};
      SEG_C:     {hit, nibble} = {1'b1, 4'hC};
      SEG_D:     {hit, nibble} = {1'b1, 4'hD};
      SEG_E:     {hit, nibble} = {1'b1, 4'hE};
      SEG_F:     {hit, nibble} = {1'b1, 4'hF};
      SEG_BLANK: blank = 1'b1;
      default:   hit = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_capture.sv
// Reads back a multiplexed active-low 7-segment bus and recovers the hex digit shown
// on each anode; a pattern commits once after STABLE_CYCLES identical synchronized samples.
module seg7_capture
  import seg7_defs::*;
#(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  seg7_capture_if.slave       bus
);

  localparam int BUS_W = DIGITS + SEG_W;
  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [BUS_W-1:0]  sync1, sync2, prev;
  logic [BUS_W-1:0]  sample;
  logic [CNT_W-1:0]  cnt;
  logic              committed;

  logic [SEG_W-1:0]  prev_seg;
  logic [DIGITS-1:0] prev_an;
  logic [NIB_W-1:0]  dec_nibble;
  logic              dec_hit, dec_blank;
  commit_kind_t      kind;
  logic [IDX_W-1:0]  idx;
  logic              commit;

  assign sample   = sync2;
  assign prev_seg = prev[SEG_W-1:0];
  assign prev_an  = prev[BUS_W-1:SEG_W];

  // Idle bus is all-ones, so the synchronizer resets to that rather than zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      // NOTE: non-blocking assignments make each flop take the pre-edge value of its source.
      sync1 <= {bus.an_n, bus.seg_n};
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev      <= '0;
      cnt       <= '0;
      committed <= 1'b0;
    end else begin
      prev <= sample;
      if (sample != prev) begin
        cnt       <= CNT_W'(1);
        committed <= 1'b0;
      end else begin
        if (cnt < CNT_W'(STABLE_CYCLES)) cnt <= cnt + 1'b1;
        if (commit)                      committed <= 1'b1;
      end
    end
  end

  seg7_pattern_decode u_decode (
    .seg_n  (prev_seg),
    .nibble (dec_nibble),
    .hit    (dec_hit),
    .blank  (dec_blank)
  );

  always_comb begin
    kind = CK_ILLEGAL;
    if (dec_hit)        kind = CK_GLYPH;
    else if (dec_blank) kind = CK_BLANK;
  end

  always_comb begin
    idx = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (!prev_an[i]) idx = IDX_W'(i);
    end
  end

  // A commit needs a single selected digit; none or several low anodes are ignored.
  assign commit = (cnt == CNT_W'(STABLE_CYCLES)) && !committed && $onehot(~prev_an);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.digits_o    <= '0;
      bus.digit_valid <= '0;
      bus.digit_err   <= '0;
      bus.update      <= 1'b0;
      bus.err_pulse   <= 1'b0;
    end else begin
      bus.update    <= 1'b0;
      bus.err_pulse <= 1'b0;
      if (commit) begin
        case (kind)
          CK_GLYPH: begin
            bus.digits_o[NIB_W*idx +: NIB_W] <= dec_nibble;
            bus.digit_valid[idx]             <= 1'b1;
            bus.digit_err[idx]               <= 1'b0;
            if (!bus.digit_valid[idx] || (bus.digits_o[NIB_W*idx +: NIB_W] != dec_nibble))
              bus.update <= 1'b1;
          end
          CK_BLANK: begin
            bus.digit_valid[idx] <= 1'b0;
            bus.digit_err[idx]   <= 1'b0;
            if (bus.digit_valid[idx]) bus.update <= 1'b1;
          end
          default: begin
            bus.digit_valid[idx] <= 1'b0;
            bus.digit_err[idx]   <= 1'b1;
            bus.err_pulse        <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_seg7_capture.sv
// Directed bench for seg7_capture: latency, scan, illegal, glitch, blank, multi-anode, reset.
module tb_seg7_capture;
  import seg7_defs::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   upd_cnt;
  int   err_cnt;

  seg7_capture_if #(.DIGITS(4)) bus ();

  seg7_capture #(.DIGITS(4), .STABLE_CYCLES(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters, sampled 2 time units after each rising edge.
  always @(posedge clk) begin
    #2;
    if (bus.update === 1'b1)    upd_cnt++;
    if (bus.err_pulse === 1'b1) err_cnt++;
  end

  task automatic drive(input logic [3:0] an, input logic [6:0] seg, input int cycles);
    bus.an_n  = an;
    bus.seg_n = seg;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic clear_counts();
    upd_cnt = 0;
    err_cnt = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.an_n  = 4'b1111;
    bus.seg_n = SEG_BLANK;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.digits_o, bus.digit_valid, bus.digit_err, bus.update, bus.err_pulse} !== 26'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h/%b/%b want 0", bus.digits_o, bus.digit_valid, bus.digit_err);
    end
    rst_n = 1'b1;
    clear_counts();
    drive(4'b1111, SEG_BLANK, 20);
    checks++;
    if ({bus.digits_o, bus.digit_valid, bus.digit_err} !== 24'd0) begin
      errors++;
      $display("FAIL idle_outputs: got %h/%b/%b want 0", bus.digits_o, bus.digit_valid, bus.digit_err);
    end
    checks++;
    if (upd_cnt !== 0 || err_cnt !== 0) begin
      errors++;
      $display("FAIL idle_pulses: got upd=%0d err=%0d want 0/0", upd_cnt, err_cnt);
    end
  endtask

  task automatic test_latency();
    clear_counts();
    drive(4'b1110, SEG_2, 6);
    checks++;
    if (bus.digit_valid !== 4'b0000) begin
      errors++;
      $display("FAIL lat_edge6_valid: got %b want 0000", bus.digit_valid);
    end
    drive(4'b1110, SEG_2, 1);
    checks++;
    if (bus.digit_valid !== 4'b0001 || bus.digits_o[3:0] !== 4'h2) begin
      errors++;
      $display("FAIL lat_edge7: got valid=%b nib=%h want 0001/2", bus.digit_valid, bus.digits_o[3:0]);
    end
    checks++;
    if (bus.update !== 1'b1) begin
      errors++;
      $display("FAIL lat_update: got %b want 1", bus.update);
    end
    drive(4'b1110, SEG_2, 1);
    checks++;
    if (bus.update !== 1'b0) begin
      errors++;
      $display("FAIL lat_update_width: got %b want 0", bus.update);
    end
    drive(4'b1110, SEG_2, 2);
    checks++;
    if (upd_cnt !== 1) begin
      errors++;
      $display("FAIL lat_update_count: got %0d want 1", upd_cnt);
    end
  endtask

  task automatic test_scan();
    logic [3:0] ans  [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    logic [6:0] segs [4] = '{SEG_1, SEG_A, SEG_C, SEG_F};
    clear_counts();
    for (int i = 0; i < 4; i++) drive(ans[i], segs[i], 8);
    checks++;
    if (bus.digits_o !== 16'hFCA1 || bus.digit_valid !== 4'b1111) begin
      errors++;
      $display("FAIL scan_values: got %h/%b want fca1/1111", bus.digits_o, bus.digit_valid);
    end
    checks++;
    if (upd_cnt !== 4) begin
      errors++;
      $display("FAIL scan_updates: got %0d want 4", upd_cnt);
    end
    clear_counts();
    for (int i = 0; i < 4; i++) drive(ans[i], segs[i], 8);
    checks++;
    if (upd_cnt !== 0 || err_cnt !== 0 || bus.digits_o !== 16'hFCA1) begin
      errors++;
      $display("FAIL scan_repeat: got upd=%0d err=%0d val=%h want 0/0/fca1", upd_cnt, err_cnt, bus.digits_o);
    end
  endtask

  task automatic test_illegal();
    clear_counts();
    drive(4'b1101, 7'b1111110, 10);
    checks++;
    if (bus.digit_err !== 4'b0010 || bus.digit_valid !== 4'b1101) begin
      errors++;
      $display("FAIL illegal_flags: got err=%b valid=%b want 0010/1101", bus.digit_err, bus.digit_valid);
    end
    checks++;
    if (err_cnt !== 1 || upd_cnt !== 0) begin
      errors++;
      $display("FAIL illegal_pulses: got err=%0d upd=%0d want 1/0", err_cnt, upd_cnt);
    end
    checks++;
    if (bus.digits_o[7:4] !== 4'hA) begin
      errors++;
      $display("FAIL illegal_nibble: got %h want a", bus.digits_o[7:4]);
    end
  endtask

  task automatic test_glitch();
    drive(4'b1110, SEG_8, 10);
    checks++;
    if (bus.digits_o[3:0] !== 4'h8) begin
      errors++;
      $display("FAIL glitch_setup: got %h want 8", bus.digits_o[3:0]);
    end
    clear_counts();
    drive(4'b1110, SEG_0, 3);
    drive(4'b1110, SEG_8, 10);
    checks++;
    if (bus.digits_o[3:0] !== 4'h8 || bus.digit_valid[0] !== 1'b1 || upd_cnt !== 0) begin
      errors++;
      $display("FAIL glitch_ignored: got nib=%h v=%b upd=%0d want 8/1/0",
               bus.digits_o[3:0], bus.digit_valid[0], upd_cnt);
    end
  endtask

  task automatic test_blank();
    clear_counts();
    drive(4'b1011, SEG_BLANK, 10);
    checks++;
    if (bus.digit_valid !== 4'b1001 || bus.digits_o !== 16'hFCA8 || bus.digit_err !== 4'b0010) begin
      errors++;
      $display("FAIL blank_state: got %b/%h/%b want 1001/fca8/0010", bus.digit_valid, bus.digits_o, bus.digit_err);
    end
    checks++;
    if (upd_cnt !== 1 || err_cnt !== 0) begin
      errors++;
      $display("FAIL blank_pulses: got upd=%0d err=%0d want 1/0", upd_cnt, err_cnt);
    end
  endtask

  task automatic test_multi_anode();
    clear_counts();
    drive(4'b1100, SEG_5, 10);
    checks++;
    if (bus.digits_o !== 16'hFCA8 || bus.digit_valid !== 4'b1001 || bus.digit_err !== 4'b0010) begin
      errors++;
      $display("FAIL multi_state: got %h/%b/%b want fca8/1001/0010", bus.digits_o, bus.digit_valid, bus.digit_err);
    end
    checks++;
    if (upd_cnt !== 0 || err_cnt !== 0) begin
      errors++;
      $display("FAIL multi_pulses: got upd=%0d err=%0d want 0/0", upd_cnt, err_cnt);
    end
  endtask

  task automatic test_reset_mid();
    clear_counts();
    drive(4'b1110, SEG_3, 10);
    checks++;
    if (bus.digits_o !== 16'hFCA3 || upd_cnt !== 1) begin
      errors++;
      $display("FAIL pre_reset_commit: got %h upd=%0d want fca3/1", bus.digits_o, upd_cnt);
    end
    drive(4'b1110, SEG_4, 2);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.digits_o, bus.digit_valid, bus.digit_err, bus.update, bus.err_pulse} !== 26'd0) begin
      errors++;
      $display("FAIL async_reset: got %h/%b/%b want 0", bus.digits_o, bus.digit_valid, bus.digit_err);
    end
    @(negedge clk);
    drive(4'b1111, SEG_BLANK, 2);
    rst_n = 1'b1;
    clear_counts();
    drive(4'b1111, SEG_BLANK, 10);
    checks++;
    if ({bus.digits_o, bus.digit_valid, bus.digit_err} !== 24'd0 || upd_cnt !== 0 || err_cnt !== 0) begin
      errors++;
      $display("FAIL post_reset_idle: got %h/%b/%b upd=%0d", bus.digits_o, bus.digit_valid, bus.digit_err, upd_cnt);
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    upd_cnt   = 0;
    err_cnt   = 0;
    rst_n     = 1'b0;
    bus.an_n  = 4'b1111;
    bus.seg_n = SEG_BLANK;
    @(negedge clk);
    test_reset();
    test_latency();
    test_scan();
    test_illegal();
    test_glitch();
    test_blank();
    test_multi_anode();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
